bit8_1to2demux: RTL
===================

Name: bit8_1to2demux

Overview:
- 8-bit, 1-input to 2-output demultiplexer with buffering. It is the steering counterpart of the 8-bit 2:1 mux: bytes arrive on one input stream, and each byte is routed to output port 1 or port 2 according to `sel` at acceptance.
- Each output port has its own small FIFO with a valid/ready handshake, so a stalled port never corrupts the other.
- Each port keeps a count of delivered bytes for debug and lab observation.

Parameters:
- WIDTH, 8, data width of input and both outputs.
- DEPTH, 2, entries per output FIFO; power of two, minimum 2.
- CW, 8, width of each delivered-byte counter.

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on rising edge of clk.
- in  input  WIDTH  input data byte.
- in_valid  input  1  input byte present.
- sel  input  1  route select, sampled with the byte: 0 routes to out1, 1 routes to out2.
- in_ready  output  1  selected port can accept this cycle.
- out1  output  WIDTH  port 1 head-of-FIFO data.
- out1_valid  output  1  port 1 FIFO non-empty.
- out1_ready  input  1  port 1 consumer accepts.
- out2  output  WIDTH  port 2 head-of-FIFO data.
- out2_valid  output  1  port 2 FIFO non-empty.
- out2_ready  input  1  port 2 consumer accepts.
- cnt1  output  CW  bytes delivered on port 1, wrapping.
- cnt2  output  CW  bytes delivered on port 2, wrapping.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - Both FIFOs are emptied: pointers and occupancy go to 0.
  - out1_valid=0, out2_valid=0, cnt1=0, cnt2=0.
  - FIFO storage is not cleared.
  - Reset overrides every simultaneous handshake. A byte offered or popped in the reset cycle is lost or not counted.
- Output data: out1/out2 equal the FIFO head entry when valid=1, and 0 when valid=0.
- in_ready is purely combinational from sel and occupancy:
  - sel=0: in_ready = !full1.
  - sel=1: in_ready = !full2.
  - There is no combinational path from out1_ready or out2_ready to in_ready. A full FIFO refuses input even if it is being popped in the same cycle.
- Accept: in_valid & in_ready at a clk edge writes `in` into the FIFO chosen by sel. The byte is visible on that port's output the next cycle (latency 1). Ports are never written in the same cycle; only one byte is accepted per cycle.
- Deliver: outN_valid & outN_ready at a clk edge pops port N and increments cntN by 1. Wrap-around: cntN goes from 2^CW-1 to 0.
- Simultaneous push and pop on the same non-full, non-empty FIFO: occupancy is unchanged, and order is preserved (FIFO).
- Push into an empty FIFO together with pop is impossible, because valid=0 at that point. The push alone takes effect.
- Pointers are log2(DEPTH) bits and wrap naturally. Occupancy is log2(DEPTH)+1 bits.
  - full = (occupancy == DEPTH).
  - empty = (occupancy == 0).
- in_valid=0: no write regardless of sel. The sel value is a don't-care, and in_ready still reflects the sel-selected port.
- Per-port state: EMPTY, PARTIAL, FULL, derived from occupancy.
  - EMPTY to PARTIAL on push.
  - PARTIAL to FULL on push without pop.
  - FULL to PARTIAL on pop.
  - PARTIAL to EMPTY on pop without push when occupancy is 1.
- Port independence: a stalled port (ready held 0) never blocks traffic routed to the other port.
- Reset mid-stream: buffered bytes are discarded. Post-reset, the first accepted byte is the first one delivered on its port.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles, then 1 -> out1_valid=0, out2_valid=0, out1=0, out2=0, cnt1=0, cnt2=0, in_ready=1 for both sel values.
- Routing: send 8'hA5 with sel=0, then 8'h3C with sel=1, both out ready=1 -> out1=A5 on cycle+1 and out2=3C on cycle+2; cnt1=1, cnt2=1.
- Backpressure and full:
  - Stimulus: out1_ready=0; send 8'h01, 8'h02, 8'h03 with sel=0.
  - Required: the first two are accepted; in_ready=0 on the third while it is held.
  - Then raise out1_ready -> outputs 01, 02, 03 in order, and in_ready returns 1 one cycle after the first pop.
- Independence: out1_ready=0 with port 1 full; stream 4 bytes with sel=1 and out2_ready=1 -> all 4 delivered on out2, cnt2=4, port 1 contents unchanged.
- Counter wrap: deliver 256 bytes on port 2 -> cnt2 returns to 0; cnt1 stays unchanged.
- Reset mid-operation: port 1 holds 2 bytes and port 2 holds 1; assert rst_n=0 for 1 cycle -> both valids are 0 next cycle and counts are 0; a new byte 8'h77 with sel=1 then appears on out2 one cycle after acceptance.

Source files
------------

// File: rtl/bit8_1to2demux.sv
// rtl/bit8_1to2demux.sv - 1:2 byte demultiplexer with per-port FIFOs and delivered-byte counters
// Each output port owns an independent FIFO so a stalled consumer never blocks the other port.

module bit8_1to2demux_port #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter int CW    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             ready_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic             full_o,
  output logic [CW-1:0]    cnt_o
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [AW:0]      occ_q, occ_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             pop;

  assign valid_o = (occ_q != '0);
  assign full_o  = (occ_q == (AW+1)'(DEPTH));
  assign pop     = valid_o & ready_i;
  assign data_o  = valid_o ? mem_q[rptr_q] : '0;
  assign cnt_o   = cnt_q;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    occ_d  = occ_q;
    cnt_d  = cnt_q;
    if (push_i) wptr_d = wptr_q + AW'(1);
    if (pop) begin
      rptr_d = rptr_q + AW'(1);
      cnt_d  = cnt_q + CW'(1);
    end
    // Push and pop together leave occupancy unchanged.
    if (push_i && !pop)      occ_d = occ_q + (AW+1)'(1);
    else if (pop && !push_i) occ_d = occ_q - (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      occ_q  <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      occ_q  <= occ_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage is deliberately not reset; only the pointers define what is live.
  always_ff @(posedge clk) begin
    if (rst_n && push_i) mem_q[wptr_q] <= wdata_i;
  end
endmodule

module bit8_1to2demux #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter int CW    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  input  logic             in_valid,
  input  logic             sel,
  output logic             in_ready,
  output logic [WIDTH-1:0] out1,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] out2,
  output logic             out2_valid,
  input  logic             out2_ready,
  output logic [CW-1:0]    cnt1,
  output logic [CW-1:0]    cnt2
);
  logic full1, full2;
  logic push1, push2;

  // in_ready depends only on occupancy, never on the consumers' ready inputs.
  assign in_ready = sel ? !full2 : !full1;
  assign push1    = in_valid & in_ready & !sel;
  assign push2    = in_valid & in_ready & sel;

  bit8_1to2demux_port #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CW(CW)) u_port1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push1),
    .wdata_i (in),
    .ready_i (out1_ready),
    .data_o  (out1),
    .valid_o (out1_valid),
    .full_o  (full1),
    .cnt_o   (cnt1)
  );

  bit8_1to2demux_port #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CW(CW)) u_port2 (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push2),
    .wdata_i (in),
    .ready_i (out2_ready),
    .data_o  (out2),
    .valid_o (out2_valid),
    .full_o  (full2),
    .cnt_o   (cnt2)
  );
endmodule
